// File: rtl/kb_host_tx.sv
// kb_host_tx -- PS/2 host-to-device command transmitter.
//
// Sends one command byte to a PS/2 keyboard using the host-initiated
// sequence: hold the clock low (inhibit), pull data low (request-to-send),
// release the clock, then shift out 8 data bits LSB first, odd parity and
// a stop bit. Each bit is changed on a device-generated falling clock edge.
// The device ACK is read on the 12th falling edge after the clock is released.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   KB_tx_data[7:0]     command byte, latched on an accepted start
//   KB_tx_start         one-cycle request, honoured only while idle
//   KB_tx_busy          high while a transfer is in progress
//   KB_tx_done          one-cycle pulse, acknowledged transfer finished
//   KB_tx_error         one-cycle pulse, NACK or timeout
//   PS2_clk_in          raw PS/2 clock line level
//   PS2_data_in         raw PS/2 data line level
//   PS2_clk_low         open-drain enable, 1 pulls the clock line low
//   PS2_data_low        open-drain enable, 1 pulls the data line low
module kb_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] KB_tx_data,
  input  logic       KB_tx_start,
  output logic       KB_tx_busy,
  output logic       KB_tx_done,
  output logic       KB_tx_error,
  input  logic       PS2_clk_in,
  input  logic       PS2_data_in,
  output logic       PS2_clk_low,
  output logic       PS2_data_low
);

  // One counter serves both the inhibit phase and the bus timeout.
  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] INH_DATA = CW'(INHIBIT_CYCLES - 2);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQUEST, SEND, ACK, WAIT_IDLE
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [3:0]      bit_cnt_q;
  logic [9:0]      frame_q;      // {stop, parity, data[7:0]}
  logic            clk_low_q, data_low_q;
  logic            busy_q, done_q, error_q;

  logic [1:0]      clk_sync_q, data_sync_q;
  logic            clk_prev_q;
  logic            clk_s, data_s, clk_fall;

  // Two-flop synchronizers, idle-high so reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], PS2_clk_in};
      data_sync_q <= {data_sync_q[0], PS2_data_in};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  assign clk_s    = clk_sync_q[1];
  assign data_s   = data_sync_q[1];
  assign clk_fall = clk_prev_q & ~clk_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      frame_q    <= '0;
      clk_low_q  <= 1'b0;
      data_low_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          clk_low_q  <= 1'b0;
          data_low_q <= 1'b0;
          busy_q     <= 1'b0;
          if (KB_tx_start) begin
            frame_q    <= {1'b1, ~^KB_tx_data, KB_tx_data};
            bit_cnt_q  <= '0;
            cnt_q      <= '0;
            clk_low_q  <= 1'b1;
            // A one-cycle inhibit makes its first cycle also its last.
            data_low_q <= (INHIBIT_CYCLES == 1);
            busy_q     <= 1'b1;
            state_q    <= INHIBIT;
          end
        end

        INHIBIT: begin
          cnt_q <= cnt_q + 1'b1;
          // Data goes low one cycle before the clock is released.
          if (cnt_q == INH_DATA) data_low_q <= 1'b1;
          if (cnt_q == INH_LAST) begin
            clk_low_q  <= 1'b0;
            data_low_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= REQUEST;
          end
        end

        default: begin
          // Timeout is checked first so it wins over an ACK sample.
          if (cnt_q == TO_LAST) begin
            clk_low_q  <= 1'b0;
            data_low_q <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b1;
            state_q    <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            case (state_q)
              REQUEST: if (clk_fall) begin
                data_low_q <= ~frame_q[0];
                bit_cnt_q  <= 4'd1;
                state_q    <= SEND;
              end
              SEND: if (clk_fall) begin
                if (bit_cnt_q == 4'd10) begin
                  data_low_q <= 1'b0;   // release for the device ACK
                  state_q    <= ACK;
                end else begin
                  data_low_q <= ~frame_q[bit_cnt_q];
                  bit_cnt_q  <= bit_cnt_q + 4'd1;
                end
              end
              ACK: if (clk_fall) begin
                if (!data_s) begin
                  state_q <= WAIT_IDLE;
                end else begin
                  busy_q  <= 1'b0;
                  error_q <= 1'b1;
                  state_q <= IDLE;
                end
              end
              WAIT_IDLE: if (clk_s && data_s) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= IDLE;
              end
              default: state_q <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign KB_tx_busy   = busy_q;
  assign KB_tx_done   = done_q;
  assign KB_tx_error  = error_q;
  assign PS2_clk_low  = clk_low_q;
  assign PS2_data_low = data_low_q;

endmodule

// File: tb/tb_kb_host_tx.sv
// Self-checking bench for kb_host_tx with a small PS/2 device model.
// Stimulus pushes expected outcomes to a queue; a monitor pops and compares
// whenever the DUT pulses done or error.
module tb_kb_host_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] KB_tx_data;
  logic       KB_tx_start;
  logic       KB_tx_busy, KB_tx_done, KB_tx_error;
  logic       PS2_clk_low, PS2_data_low;
  logic       dev_clk_low, dev_data_low;
  wire        clk_line  = ~(PS2_clk_low | dev_clk_low);
  wire        data_line = ~(PS2_data_low | dev_data_low);

  kb_host_tx #(.INHIBIT_CYCLES(10), .TIMEOUT_CYCLES(2000)) dut (
    .clk          (clk),
    .reset        (reset),
    .KB_tx_data   (KB_tx_data),
    .KB_tx_start  (KB_tx_start),
    .KB_tx_busy   (KB_tx_busy),
    .KB_tx_done   (KB_tx_done),
    .KB_tx_error  (KB_tx_error),
    .PS2_clk_in   (clk_line),
    .PS2_data_in  (data_line),
    .PS2_clk_low  (PS2_clk_low),
    .PS2_data_low (PS2_data_low)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] kind;   // {done, error}
    bit         chk;    // compare the captured frame
    logic [7:0] data;
    logic       par;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0, n_pass = 0;
  int          evt_cnt = 0;
  logic [10:0] cap;     // [10]=start, [9]=stop, [8]=parity, [7:0]=data
  int          inh_len = 0, rel_cyc = 0, err_cyc = 0;
  logic        dl_last, dl_prev2;
  logic [1:0]  err_drv;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: inhibit timing, release/error timestamps, event scoreboard.
  initial begin
    int   run = 0;
    logic d1 = 1'b0, d2 = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (PS2_clk_low) begin
        run++; d2 = d1; d1 = PS2_data_low;
      end else begin
        if (run > 0) begin
          inh_len = run; dl_last = d1; dl_prev2 = d2; rel_cyc = cyc;
        end
        run = 0;
      end
      if (KB_tx_done || KB_tx_error) begin
        chk("done_err_exclusive", KB_tx_done & KB_tx_error, 0);
        if (KB_tx_error) begin
          err_cyc = cyc; err_drv = {PS2_clk_low, PS2_data_low};
        end
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {KB_tx_done, KB_tx_error}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", {KB_tx_done, KB_tx_error}, e.kind);
          if (e.chk) begin
            chk("frame_start",  cap[10],  0);
            chk("frame_data",   cap[7:0], e.data);
            chk("frame_parity", cap[8],   e.par);
            chk("frame_stop",   cap[9],   1);
          end
        end
        evt_cnt++;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    KB_tx_data = b; KB_tx_start = 1'b1;
    @(negedge clk);
    KB_tx_start = 1'b0;
    chk("busy_after_accept", KB_tx_busy, 1);
  endtask

  // Device model: waits for request-to-send, clocks n_edges pulses of
  // 40 clk, samples data on each rising edge, optionally drives ACK.
  task automatic device_xfer(input int n_edges, input bit ack);
    int w = 0;
    cap = '1;
    while (!(PS2_clk_low == 1'b0 && PS2_data_low == 1'b1) && w < 300) begin
      @(negedge clk); w++;
    end
    chk("request_seen", (w < 300), 1);
    if (w >= 300) return;
    repeat (10) @(negedge clk);
    cap[10] = data_line;
    for (int k = 1; k <= n_edges; k++) begin
      dev_clk_low = 1'b1;
      repeat (20) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k <= 10) cap[k-1] = data_line;
      if (k == 10 && ack) dev_data_low = 1'b1;
      repeat (20) @(negedge clk);
    end
    dev_data_low = 1'b0;
  endtask

  task automatic wait_evt(input int target, input int budget, input string nm);
    int n = 0;
    while (evt_cnt < target && n < budget) begin
      @(negedge clk); n++;
    end
    chk(nm, (evt_cnt >= target), 1);
  endtask

  initial begin
    reset = 1'b1; KB_tx_data = '0; KB_tx_start = 1'b0;
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {PS2_clk_low, PS2_data_low, KB_tx_busy, KB_tx_done, KB_tx_error}, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 0xED, ACKed: bits 1,0,1,1,0,1,1,1, parity 1
    exp_q.push_back('{2'b10, 1'b1, 8'hED, 1'b1});
    send(8'hED);
    device_xfer(12, 1'b1);
    wait_evt(1, 200, "ed_done_wait");
    chk("ed_busy_after", KB_tx_busy, 0);
    chk("inhibit_len", inh_len, 10);
    chk("inhibit_data_last", dl_last, 1);
    chk("inhibit_data_early", dl_prev2, 0);
    repeat (10) @(negedge clk);

    // 0xF4, ACKed: five ones -> parity 0
    exp_q.push_back('{2'b10, 1'b1, 8'hF4, 1'b0});
    send(8'hF4);
    device_xfer(12, 1'b1);
    wait_evt(2, 200, "f4_done_wait");
    repeat (10) @(negedge clk);

    // 0x00, device never ACKs: parity 1, error
    exp_q.push_back('{2'b01, 1'b1, 8'h00, 1'b1});
    send(8'h00);
    device_xfer(12, 1'b0);
    wait_evt(3, 200, "nack_err_wait");
    chk("nack_busy_after", KB_tx_busy, 0);
    repeat (10) @(negedge clk);

    // 0xFF, device never clocks: timeout 2000 cycles after release
    exp_q.push_back('{2'b01, 1'b0, 8'hFF, 1'b0});
    send(8'hFF);
    wait_evt(4, 3000, "timeout_wait");
    chk("timeout_latency", err_cyc - rel_cyc, 2000);
    chk("timeout_drives", err_drv, 0);
    repeat (10) @(negedge clk);

    // 0xAA aborted by reset while data bit 3 is on the wire
    send(8'hAA);
    device_xfer(4, 1'b1);
    chk("mid_bit3_drive", PS2_data_low, 0);   // bit3 of 0xAA is 1 -> released
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_state", {PS2_clk_low, PS2_data_low, KB_tx_busy, KB_tx_done, KB_tx_error}, 0);
    reset = 1'b0;
    repeat (50) @(negedge clk);

    // Following 0xAA completes normally: parity 1
    exp_q.push_back('{2'b10, 1'b1, 8'hAA, 1'b1});
    send(8'hAA);
    device_xfer(12, 1'b1);
    wait_evt(5, 200, "aa_done_wait");
    repeat (10) @(negedge clk);

    // 0xED again with a 0x55 start pulsed mid-transfer: must be ignored
    exp_q.push_back('{2'b10, 1'b1, 8'hED, 1'b1});
    send(8'hED);
    fork
      device_xfer(12, 1'b1);
      begin
        repeat (100) @(negedge clk);
        KB_tx_data = 8'h55; KB_tx_start = 1'b1;
        @(negedge clk);
        KB_tx_start = 1'b0;
      end
    join
    wait_evt(6, 200, "ed2_done_wait");
    repeat (60) @(negedge clk);
    chk("no_queued_tx", {KB_tx_busy, PS2_clk_low}, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("event_count", evt_cnt, 6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/kb_host_tx.md
KB_HOST_TX -- requirements
Module: kb_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000, clk cycles PS2_clk is held low before the request (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 750000, clk cycles allowed from clock release to end of ACK (15 ms at 50 MHz).
REQ-003 Port clk  input  1  system clock, all logic on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port KB_tx_data  input  8  command byte to send to the keyboard.
REQ-006 Port KB_tx_start  input  1  one-cycle request; accepted only when KB_tx_busy=0.
REQ-007 Port KB_tx_busy  output  1  high from the cycle after acceptance until the return to IDLE.
REQ-008 Port KB_tx_done  output  1  one-cycle pulse on successful, acknowledged transfer.
REQ-009 Port KB_tx_error  output  1  one-cycle pulse on missing ACK or timeout.
REQ-010 Port PS2_clk_in  input  1  raw PS/2 clock line level.
REQ-011 Port PS2_data_in  input  1  raw PS/2 data line level.
REQ-012 Port PS2_clk_low  output  1  1 = drive PS/2 clock low (open-drain enable); 0 = release.
REQ-013 Port PS2_data_low  output  1  1 = drive PS/2 data low; 0 = release.

Function
REQ-014 PS2_clk_in and PS2_data_in SHALL each pass through a 2-flop synchronizer; a falling edge SHALL be detected as synchronized previous=1, current=0.
REQ-015 States SHALL be IDLE, INHIBIT, REQUEST, SEND, ACK, WAIT_IDLE.
REQ-016 IDLE: KB_tx_start=1 SHALL latch KB_tx_data, compute odd parity (parity = ~^data), clear the bit counter, and enter INHIBIT on the next edge.
REQ-017 INHIBIT: PS2_clk_low=1 for exactly INHIBIT_CYCLES cycles; PS2_data_low SHALL rise to 1 in the last INHIBIT cycle; then enter REQUEST.
REQ-018 REQUEST: PS2_clk_low=0, PS2_data_low=1 (start bit); the timeout counter starts at 0; on the first falling edge, go to SEND.
REQ-019 SEND: on the falling edge that enters SEND and on each subsequent falling edge, the next frame bit SHALL be presented: data bits 0-7 (LSB first), then parity, then stop (released).
REQ-020 SEND: PS2_data_low = ~bit for data and parity bits; for the stop bit PS2_data_low=0.
REQ-021 The 11th falling edge after clock release SHALL move to ACK with PS2_data_low=0.
REQ-022 ACK: the synchronized data level SHALL be sampled on the 12th falling edge; 0 -> WAIT_IDLE; 1 -> pulse KB_tx_error and return to IDLE.
REQ-023 WAIT_IDLE: when both synchronized lines read 1, KB_tx_done SHALL pulse for one cycle and the state SHALL return to IDLE.
REQ-024 Timeout: if the counter reaches TIMEOUT_CYCLES in REQUEST, SEND, ACK or WAIT_IDLE, KB_tx_error SHALL pulse, both drive outputs SHALL release, and the state SHALL return to IDLE on the same edge.
REQ-025 KB_tx_start while busy SHALL be ignored with no queuing; KB_tx_done and KB_tx_error SHALL never assert in the same cycle.
REQ-026 Simultaneous timeout and ACK sample on the same edge: timeout SHALL win.
REQ-027 In IDLE, PS2_clk_low=0 and PS2_data_low=0, so the receiver path owns the bus.

Reset
REQ-028 reset=1 SHALL, at the next clk edge, force IDLE, PS2_clk_low=0, PS2_data_low=0, KB_tx_busy=0, KB_tx_done=0, KB_tx_error=0, clear all counters and synchronizers to 1, regardless of the current state.
REQ-029 reset asserted mid-transfer SHALL NOT produce a done or error pulse.

Verification (INHIBIT_CYCLES=10, TIMEOUT_CYCLES=2000; device model clocks the bus at 40 clk/period)
REQ-030 Send 0xED with the device ACKing -> PS2_clk_low high for 10 cycles; the model captures bits 1,0,1,1,0,1,1,1, parity 1, stop 1; one KB_tx_done pulse; busy is 0 after.
REQ-031 Send 0xF4 with the device ACKing -> the model captures parity 0 (5 ones); KB_tx_done pulses.
REQ-032 Send 0x00 with the device not pulling data low on the ACK pulse -> parity 1; KB_tx_error pulses once, KB_tx_done stays 0.
REQ-033 Send 0xFF with the device never clocking -> KB_tx_error pulses 2000 cycles after clock release; both drive outputs are 0.
REQ-034 Assert reset during data bit 3 of 0xAA -> the next cycle shows both drives 0, busy 0, no pulses; a following 0xAA transfer completes normally.
REQ-035 Pulse KB_tx_start with 0x55 during the 0xED transfer -> ignored; the model receives only 0xED.
